// File: rtl/run_seq_gen_pkg.sv
// Shared definitions for the serial run-length generator: FSM state encoding and default gap length.
package run_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_GAP = 1;

endpackage

// File: rtl/run_seq_gen_cnt_down_ld.sv
// Loadable down-counter with synchronous clear, load, saturating decrement and zero flag.
module cnt_down_ld
    import run_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    // Decrement stops at zero so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/run_seq_gen.sv
// Serial run-length generator: emits i_len ones then GAP zeros per accepted request.
// Define RUN_SEQ_GEN_PIPE_EN to accept the next request during the final gap bit.
module run_seq_gen
    import run_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_len,
    output logic             o_ready,
    output logic             o_dat,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned GW = $clog2(GAP + 1);

    if (GAP < 1) begin : g_bad_gap
        $error("run_seq_gen: GAP must be at least 1");
    end

    state_e state_d, state_q;
    logic   dat_d, dat_q;
    logic   busy_d, busy_q;
    logic   rem_ld, rem_dec, rem_zero;
    logic   gcnt_ld, gcnt_dec, gcnt_zero;
    logic   accept;

`ifdef RUN_SEQ_GEN_PIPE_EN
    assign o_ready = i_en && ((state_q == S_IDLE) || ((state_q == S_GAP) && gcnt_zero));
`else
    assign o_ready = i_en && (state_q == S_IDLE);
`endif

    assign accept = i_valid && o_ready;
    assign o_done = (state_q == S_GAP) && gcnt_zero;
    assign o_dat  = dat_q;
    assign o_busy = busy_q;

    // A zero-length request skips RUN and goes straight to the gap.
    always_comb begin
        state_d  = state_q;
        rem_ld   = 1'b0;
        rem_dec  = 1'b0;
        gcnt_ld  = 1'b0;
        gcnt_dec = 1'b0;
        if (i_sclr) begin
            state_d = S_IDLE;
        end else if (i_en) begin
            case (state_q)
                S_IDLE, S_GAP: begin
                    if ((state_q == S_GAP) && !gcnt_zero) begin
                        gcnt_dec = 1'b1;
                    end else if (accept) begin
                        if (i_len != '0) begin
                            state_d = S_RUN;
                            rem_ld  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gcnt_ld = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (rem_zero) begin
                        state_d = S_GAP;
                        gcnt_ld = 1'b1;
                    end else begin
                        rem_dec = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        dat_d  = (state_d == S_RUN);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            dat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

    cnt_down_ld #(.WIDTH(WIDTH)) u_rem (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .clr      (i_sclr),
        .load     (rem_ld),
        .load_val (i_len - 1'b1),
        .dec      (rem_dec),
        .zero     (rem_zero)
    );

    cnt_down_ld #(.WIDTH(GW)) u_gcnt (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .clr      (i_sclr),
        .load     (gcnt_ld),
        .load_val (GW'(GAP - 1)),
        .dec      (gcnt_dec),
        .zero     (gcnt_zero)
    );

endmodule

// File: tb/tb_run_seq_gen.sv
// Scoreboard bench for run_seq_gen (WIDTH=3, GAP=1) with a consecutive-ones counter loopback model.
module tb_run_seq_gen;

    localparam int unsigned W   = 3;
    localparam int unsigned GAP = 1;

    typedef struct packed {
        logic dat;
        logic done;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst_n, i_sclr, i_en, i_valid;
    logic [W-1:0] i_len;
    logic         o_ready, o_dat, o_busy, o_done;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           lb_cnt;
    int           peak;
    logic [6:0]   b2b_pat;
    logic [6:0]   b2b_exp;

    always #5 clk = ~clk;

    run_seq_gen #(.WIDTH(W), .GAP(GAP)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (i_sclr),
        .i_en    (i_en),
        .i_valid (i_valid),
        .i_len   (i_len),
        .o_ready (o_ready),
        .o_dat   (o_dat),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Loopback model of counter_seq_en: counts consecutive enabled 1s.
    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)    lb_cnt <= 0;
        else if (i_sclr) lb_cnt <= 0;
        else if (i_en)   lb_cnt <= o_dat ? lb_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (lb_cnt > peak) peak = lb_cnt;
    end

    // Monitor: pop one expected bit per enabled busy cycle; stalled cycles must show the same bit.
    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_busy) begin
                if (exp_q.size() == 0) begin
                    check("busy_with_empty_queue", o_busy, 0);
                end else begin
                    mon_e = exp_q[0];
                    check("dat", o_dat, mon_e.dat);
                    check("done", o_done, mon_e.done);
                    if (i_en) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_dat", o_dat, 0);
                check("idle_done", o_done, 0);
            end
        end
    end

    task automatic push_run(input int len);
        for (int i = 0; i < len; i++) exp_q.push_back('{dat: 1'b1, done: 1'b0});
        for (int g = 0; g < int'(GAP) - 1; g++) exp_q.push_back('{dat: 1'b0, done: 1'b0});
        exp_q.push_back('{dat: 1'b0, done: 1'b1});
    endtask

    task automatic send(input int len, input bit keep);
        bit got;
        logic [31:0] lv;
        got = 1'b0;
        lv = len;
        i_valid = 1'b1;
        i_len = lv[W-1:0];
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
        end
        check("accept_timeout", got, 1);
        if (got) push_run(len);
        @(posedge clk);
        #1;
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (o_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", o_busy, 0);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_sclr  = 1'b0;
        i_en    = 1'b1;
        i_valid = 1'b0;
        i_len   = '0;
        peak    = 0;
        #3;
        check("rst_dat", o_dat, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", o_ready, 1);
        @(posedge clk);
        #1;

        // Length 3
        peak = 0;
        send(3, 1'b0);
        wait_idle();
        check("len3_peak", peak, 3);

        // Length 0
        peak = 0;
        send(0, 1'b0);
        wait_idle();
        check("len0_peak", peak, 0);

        // Maximum length with a two-cycle stall after the third bit
        peak = 0;
        send(7, 1'b0);
        repeat (3) @(posedge clk);
        #1 i_en = 1'b0;
        @(negedge clk);
        check("stall_dat", o_dat, 1);
        check("stall_ready", o_ready, 0);
        repeat (2) @(posedge clk);
        #1 i_en = 1'b1;
        wait_idle();
        check("len7_peak", peak, 7);

        // Synchronous clear mid-run
        send(5, 1'b0);
        @(posedge clk);
        #1 i_sclr = 1'b1;
        @(posedge clk);
        #1 i_sclr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("sclr_dat", o_dat, 0);
        check("sclr_busy", o_busy, 0);
        check("sclr_ready", o_ready, 1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run
        send(5, 1'b0);
        @(posedge clk);
        #3 i_rst_n = 1'b0;
        #1;
        check("arst_dat", o_dat, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        exp_q.delete();
        @(posedge clk);
        #1 i_rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", o_ready, 1);
        check("arst_idle_dat", o_dat, 0);
        @(posedge clk);
        #1;

        // Back-to-back requests with i_valid held
`ifdef RUN_SEQ_GEN_PIPE_EN
        b2b_exp = 7'b1101100;
`else
        b2b_exp = 7'b1100110;
`endif
        fork
            begin
                send(2, 1'b1);
                send(2, 1'b0);
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    b2b_pat[6-i] = o_dat;
                end
            end
        join
        wait_idle();
        check("b2b_pattern", b2b_pat, b2b_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
